// File: rtl/io_switch_pkg.sv
// io_switch_pkg: shared constants and types for the io_switch input peripheral.
//   - bus base address / decode mask types and default values
//   - register word offsets and the EDGE_SEL reset image
//   - byte-enable expansion helper used by the register write logic
package io_switch_pkg;

    typedef logic [31:0] base_addr_type;
    typedef logic [31:0] addr_mask_type;

    localparam base_addr_type CFG_BADR_SW = 32'h0000_0100;
    localparam addr_mask_type CFG_MADR_SW = 32'hFFFF_FF00;

    localparam logic [31:0] SW_OFS_STATE = 32'h0000_0000;
    localparam logic [31:0] SW_OFS_EDGE  = 32'h0000_0004;
    localparam logic [31:0] SW_OFS_IE    = 32'h0000_0008;
    localparam logic [31:0] SW_OFS_SEL   = 32'h0000_000C;

    // EDGE_SEL after reset: rise detection on every pin, fall detection off.
    localparam logic [31:0] SW_SEL_RESET = 32'h0000_00FF;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/data_bus.sv
// DATA_BUS: simple single-cycle request / registered-ack register bus.
//   req/we/addr/be/wdata driven by the master; ack/rdata returned by the slave
//   exactly one cycle after the request cycle.
interface DATA_BUS;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport Master (output req, we, addr, be, wdata, input ack, rdata);
    modport Slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/io_debounce.sv
// io_debounce: one input bit -- 2-FF synchroniser, stability counter, stable level FF.
//   clk, rst : clock, synchronous active-high reset
//   sw       : raw asynchronous pin
//   stable   : debounced level (registered)
//   rise/fall: combinational pulses, high in the cycle whose clock edge updates stable
module io_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised level disagrees with the accepted one,
    // so any glitch shorter than DEBOUNCE_CYCLES restarts it from zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= sw;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = stable_d & ~stable_q;
    assign fall   = ~stable_d & stable_q;

endmodule

// File: rtl/io_switch.sv
// io_switch: memory-mapped debounced switch/button input port with edge capture and irq.
//   clk, rst : clock, synchronous active-high reset
//   sw       : WIDTH raw pin inputs
//   irq      : registered level interrupt, |(EDGE & IE)
//   dslv     : DATA_BUS slave; STATE (RO), EDGE (W1C), IE (RW), EDGE_SEL (RW)
module io_switch
    import io_switch_pkg::*;
#(
    parameter base_addr_type base_addr       = CFG_BADR_SW,
    parameter addr_mask_type addr_mask       = CFG_MADR_SW,
    parameter int unsigned   WIDTH           = 8,
    parameter int unsigned   DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic             irq,
    DATA_BUS.Slave           dslv
);

    // FALL_EN sits above an 8-bit RISE_EN field, or above a 16-bit one for wide ports.
    localparam int unsigned FALL_LSB = (WIDTH > 8) ? 16 : 8;

    logic [WIDTH-1:0] stable, rise, fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .sw    (sw[i]),
            .stable(stable[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic             irq_q, irq_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        sel;
    logic [31:0] ofs;
    logic [31:0] wmask;
    logic [31:0] wbits;

    assign sel   = dslv.req && ((dslv.addr & addr_mask) == base_addr);
    assign ofs   = dslv.addr & ~addr_mask;
    assign wmask = be_to_mask(dslv.be);
    assign wbits = dslv.wdata & wmask;

    always_comb begin
        edge_d    = edge_q;
        ie_d      = ie_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        rdata_d   = '0;
        ack_d     = sel;

        if (sel && dslv.we) begin
            case (ofs)
                SW_OFS_EDGE: edge_d = edge_q & ~wbits[WIDTH-1:0];
                SW_OFS_IE:   ie_d = (ie_q & ~wmask[WIDTH-1:0]) | wbits[WIDTH-1:0];
                SW_OFS_SEL: begin
                    rise_en_d = (rise_en_q & ~wmask[WIDTH-1:0]) | wbits[WIDTH-1:0];
                    fall_en_d = (fall_en_q & ~wmask[FALL_LSB +: WIDTH])
                              | wbits[FALL_LSB +: WIDTH];
                end
                default: ;
            endcase
        end

        // Reads sample the registers before this cycle's updates take effect.
        if (sel && !dslv.we) begin
            case (ofs)
                SW_OFS_STATE: rdata_d[WIDTH-1:0] = stable;
                SW_OFS_EDGE:  rdata_d[WIDTH-1:0] = edge_q;
                SW_OFS_IE:    rdata_d[WIDTH-1:0] = ie_q;
                SW_OFS_SEL: begin
                    rdata_d[WIDTH-1:0]         = rise_en_q;
                    rdata_d[FALL_LSB +: WIDTH] = fall_en_q;
                end
                default: ;
            endcase
        end

        // Applied after the W1C so a newly captured edge survives a same-cycle clear.
        edge_d = edge_d | (rise & rise_en_q) | (fall & fall_en_q);

        irq_d = |(edge_q & ie_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q    <= '0;
            ie_q      <= '0;
            rise_en_q <= '1;
            fall_en_q <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            edge_q    <= edge_d;
            ie_q      <= ie_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign irq        = irq_q;
    assign dslv.ack   = ack_q;
    assign dslv.rdata = rdata_q;

endmodule

// File: tb/tb_io_switch.sv
// tb_io_switch: directed bench for io_switch with DEBOUNCE_CYCLES = 4.
module tb_io_switch;
    import io_switch_pkg::*;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = '0;
    logic       irq;

    DATA_BUS bus ();

    io_switch #(
        .base_addr      (CFG_BADR_SW),
        .addr_mask      (CFG_MADR_SW),
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .irq (irq),
        .dslv(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] ofs;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        exp_ack;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [31:0] ofs, input logic [3:0] be,
                                input logic [31:0] wd, input logic exp_ack, input logic chk_rd,
                                input logic [31:0] exp_rd);
        vec_t v;
        v.we = we; v.ofs = ofs; v.be = be; v.wd = wd;
        v.exp_ack = exp_ack; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_acc(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, output logic ack, output logic [31:0] rd);
        bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.be = be; bus.wdata = wd;
        tick();
        ack = bus.ack;
        rd  = bus.rdata;
        bus.req = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] ofs, input logic [31:0] exp);
        logic        a;
        logic [31:0] r;
        bus_acc(1'b0, CFG_BADR_SW + ofs, 4'hF, 32'h0, a, r);
        check({name, " ack"}, {31'b0, a}, 32'd1);
        check(name, r, exp);
    endtask

    task automatic wr(input string name, input logic [31:0] ofs, input logic [3:0] be,
                      input logic [31:0] wd);
        logic        a;
        logic [31:0] r;
        bus_acc(1'b1, CFG_BADR_SW + ofs, be, wd, a, r);
        check({name, " ack"}, {31'b0, a}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        a;
        logic [31:0] r;
        logic [31:0] b2b_exp [4];

        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0;

        // Register access vectors after reset with all pins low.
        vecs.push_back(mk(0, 32'h00, 4'hF, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 32'h04, 4'hF, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 32'h08, 4'hF, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 32'h0C, 4'hF, 32'h0,         1, 1, SW_SEL_RESET));
        vecs.push_back(mk(1, 32'h08, 4'h0, 32'hFF,        1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h08, 4'hF, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h08, 4'hF, 32'hFFFF_FFA5, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h08, 4'hF, 32'h0,         1, 1, 32'hA5));
        vecs.push_back(mk(1, 32'h0C, 4'h2, 32'h0000_1200, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0C, 4'hF, 32'h0,         1, 1, 32'h12FF));
        vecs.push_back(mk(1, 32'h0C, 4'h1, 32'h0,         1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0C, 4'hF, 32'h0,         1, 1, 32'h1200));
        vecs.push_back(mk(1, 32'h10, 4'hF, 32'hFFFF_FFFF, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h10, 4'hF, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h00, 4'hF, 32'hFF,        1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h00, 4'hF, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 32'h104, 4'hF, 32'h0,        0, 1, 32'h0));
        vecs.push_back(mk(1, 32'h08, 4'hF, 32'h0,         1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h0C, 4'hF, 32'h00FF,      1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0C, 4'hF, 32'h0,         1, 1, 32'h00FF));

        ticks(3);
        check("irq in reset", {31'b0, irq}, 32'd0);
        check("ack in reset", {31'b0, bus.ack}, 32'd0);
        rst = 1'b0;
        tick();

        // 1. Table-driven register accesses; each ack must be a single-cycle pulse.
        foreach (vecs[i]) begin
            bus_acc(vecs[i].we, CFG_BADR_SW + vecs[i].ofs, vecs[i].be, vecs[i].wd, a, r);
            check($sformatf("vec%0d ack", i), {31'b0, a}, {31'b0, vecs[i].exp_ack});
            if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), r, vecs[i].exp_rd);
            tick();
            check($sformatf("vec%0d ack drop", i), {31'b0, bus.ack}, 32'd0);
        end
        check("irq idle", {31'b0, irq}, 32'd0);

        // Back-to-back reads: one ack per request cycle.
        b2b_exp[0] = 32'h0; b2b_exp[1] = 32'h0; b2b_exp[2] = 32'h0; b2b_exp[3] = SW_SEL_RESET;
        bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus.addr = CFG_BADR_SW + 32'(i * 4);
            tick();
            check($sformatf("b2b%0d ack", i), {31'b0, bus.ack}, 32'd1);
            check($sformatf("b2b%0d rdata", i), bus.rdata, b2b_exp[i]);
        end
        bus.req = 1'b0;
        tick();
        check("b2b ack drop", {31'b0, bus.ack}, 32'd0);

        // 2. sw[0] rise: STATE visible in the cycle after the 6th clock edge.
        sw[0] = 1'b1;
        ticks(5);
        rd_chk("t2 state early", 32'h0, 32'h00);
        rd_chk("t2 state", 32'h0, 32'h01);
        rd_chk("t2 edge", 32'h4, 32'h01);
        check("t2 irq masked", {31'b0, irq}, 32'd0);
        wr("t2 ie", 32'h8, 4'hF, 32'h01);
        check("t2 irq not yet", {31'b0, irq}, 32'd0);
        tick();
        check("t2 irq", {31'b0, irq}, 32'd1);

        // 3a. 3-cycle glitch on sw[1] is rejected.
        sw[1] = 1'b1;
        ticks(3);
        sw[1] = 1'b0;
        ticks(10);
        rd_chk("t3 glitch state", 32'h0, 32'h01);
        rd_chk("t3 glitch edge", 32'h4, 32'h01);
        check("t3 irq held", {31'b0, irq}, 32'd1);

        // 3b. 5-cycle pulse with fall-only on bit1: edge only after release qualifies.
        wr("t3 sel", 32'hC, 4'hF, 32'h0200);
        wr("t3 w1c", 32'h4, 4'hF, 32'hFF);
        sw[1] = 1'b1;
        ticks(5);
        sw[1] = 1'b0;
        rd_chk("t3 state pre", 32'h0, 32'h01);
        rd_chk("t3 state high", 32'h0, 32'h03);
        rd_chk("t3 edge after rise", 32'h4, 32'h00);
        ticks(2);
        rd_chk("t3 edge before fall", 32'h4, 32'h00);
        rd_chk("t3 edge fall", 32'h4, 32'h02);
        rd_chk("t3 state low", 32'h0, 32'h01);
        check("t3 irq", {31'b0, irq}, 32'd0);

        // 4. W1C colliding with a newly captured rise on bit0: the edge wins.
        wr("t4 sel", 32'hC, 4'hF, 32'h00FF);
        wr("t4 w1c all", 32'h4, 4'hF, 32'hFF);
        sw[0] = 1'b0;
        ticks(10);
        rd_chk("t4 edge after fall", 32'h4, 32'h00);
        check("t4 irq low", {31'b0, irq}, 32'd0);
        sw[0] = 1'b1;
        ticks(5);
        wr("t4 w1c collide", 32'h4, 4'hF, 32'h01);
        rd_chk("t4 edge kept", 32'h4, 32'h01);
        check("t4 irq set", {31'b0, irq}, 32'd1);
        wr("t4 w1c", 32'h4, 4'hF, 32'h01);
        check("t4 irq lag", {31'b0, irq}, 32'd1);
        tick();
        check("t4 irq clr", {31'b0, irq}, 32'd0);
        rd_chk("t4 edge clr", 32'h4, 32'h00);

        // 5. Reset at counter=2 on bit2 with a request in flight.
        sw[2] = 1'b1;
        ticks(4);
        rst = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = CFG_BADR_SW; bus.be = 4'hF;
        tick();
        rst = 1'b0;
        bus.req = 1'b0;
        check("t5 no ack", {31'b0, bus.ack}, 32'd0);
        check("t5 irq rst", {31'b0, irq}, 32'd0);
        tick();
        check("t5 no ack late", {31'b0, bus.ack}, 32'd0);
        ticks(4);
        rd_chk("t5 state early", 32'h0, 32'h00);
        rd_chk("t5 state", 32'h0, 32'h05);
        rd_chk("t5 edge", 32'h4, 32'h05);
        rd_chk("t5 ie", 32'h8, 32'h00);
        rd_chk("t5 sel", 32'hC, SW_SEL_RESET);
        check("t5 irq", {31'b0, irq}, 32'd0);
        wr("t5 unmapped wr", 32'h10, 4'hF, 32'hFF);
        rd_chk("t5 unmapped rd", 32'h10, 32'h00);
        rd_chk("t5 ie kept", 32'h8, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
